// File: rtl/pc_gen.sv
// Fetch-stage program counter: prioritised redirects, holds and back-pressure,
// with a small direct-mapped BTB for taken-branch prediction.
module pc_gen #(
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              INST_BYTES  = 4,
  parameter int              HOLD_W      = 3,
  parameter int              HOLD_PC_BIT = 0,
  parameter int              BTB_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [HOLD_W-1:0] hold_flag,
  input  logic              fetch_ready,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              pred_taken,
  output logic              misalign
);

  localparam int ALIGN_W = $clog2(INST_BYTES);
  localparam int IDX_W   = $clog2(BTB_DEPTH);
  localparam int TAG_W   = ADDR_W - ALIGN_W - IDX_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    {{(ADDR_W-ALIGN_W){1'b1}}, {ALIGN_W{1'b0}}};

  logic [BTB_DEPTH-1:0] btb_vld;
  logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
  logic [ADDR_W-1:0]    btb_tgt [BTB_DEPTH];

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic [TAG_W-1:0]  wr_tag;
  logic              hit;
  logic              redir;
  logic              stall;
  logic [ADDR_W-1:0] redir_tgt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              pred_nxt;
  logic              mis_nxt;
  logic              unused;

  assign unused = ^{upd_pc[ALIGN_W-1:0], hold_flag};

  assign rd_idx = pc[ALIGN_W+IDX_W-1:ALIGN_W];
  assign rd_tag = pc[ADDR_W-1:ALIGN_W+IDX_W];
  assign wr_idx = upd_pc[ALIGN_W+IDX_W-1:ALIGN_W];
  assign wr_tag = upd_pc[ADDR_W-1:ALIGN_W+IDX_W];
  assign hit    = btb_vld[rd_idx] && (btb_tag[rd_idx] == rd_tag);

  assign redir     = ce && (trap_valid || jump_flag);
  assign redir_tgt = trap_valid ? trap_addr : jump_addr;
  assign stall     = hold_flag[HOLD_PC_BIT] || !fetch_ready;
  assign mis_nxt   = redir && (|redir_tgt[ALIGN_W-1:0]);

  always_comb begin
    pc_nxt   = pc;
    pred_nxt = pred_taken;
    if (!ce) begin
      pc_nxt   = pc;
    end else if (redir) begin
      pc_nxt   = redir_tgt & ALIGN_MASK;
      pred_nxt = 1'b0;
    end else if (stall) begin
      pc_nxt   = pc;
    end else if (hit) begin
      pc_nxt   = btb_tgt[rd_idx];
      pred_nxt = 1'b1;
    end else begin
      pc_nxt   = pc + STEP;
      pred_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VEC;
      ce         <= 1'b0;
      pred_taken <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      pc         <= pc_nxt;
      ce         <= 1'b1;
      pred_taken <= pred_nxt;
      misalign   <= mis_nxt;
    end
  end

  // Not-taken training only evicts the entry it actually owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_vld <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        btb_vld[wr_idx] <= 1'b1;
      end else if (btb_tag[wr_idx] == wr_tag) begin
        btb_vld[wr_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      btb_tag[wr_idx] <= wr_tag;
      btb_tgt[wr_idx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid;
  logic [31:0] trap_addr;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [2:0]  hold_flag;
  logic        fetch_ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc;
  logic        ce;
  logic        pred_taken;
  logic        misalign;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_addr(trap_addr),
    .jump_flag(jump_flag), .jump_addr(jump_addr),
    .hold_flag(hold_flag), .fetch_ready(fetch_ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .pc(pc), .ce(ce), .pred_taken(pred_taken),
    .misalign(misalign)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        pred;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Model state: BTB held as slot -> (valid, trained line, target).
  logic [31:0] m_pc = 0;
  bit          m_ce = 0;
  bit          m_pred = 0;
  bit          bv[8];
  logic [31:0] bline[8];
  logic [31:0] btgt[8];

  task automatic idle();
    rst = 0; trap_valid = 0; trap_addr = 0;
    jump_flag = 0; jump_addr = 0; hold_flag = 0;
    fetch_ready = 1; upd_valid = 0; upd_pc = 0;
    upd_target = 0; upd_taken = 0;
  endtask

  task automatic cyc();
    exp_t e;
    int s;
    int u;
    bit h;
    bit mis;
    logic [31:0] t;
    s = int'((m_pc / 4) % 8);
    h = bv[s] && (bline[s] == m_pc / 32);
    mis = 0;
    if (rst) begin
      m_ce = 0; m_pc = 0; m_pred = 0;
      for (int k = 0; k < 8; k++) bv[k] = 0;
    end else begin
      if (!m_ce) begin
        m_ce = 1;
      end else if (trap_valid || jump_flag) begin
        t = trap_valid ? trap_addr : jump_addr;
        mis = (t % 4) != 0;
        m_pc = t - (t % 4);
        m_pred = 0;
      end else if (hold_flag[0] || !fetch_ready) begin
        m_pred = m_pred;
      end else if (h) begin
        m_pc = btgt[s];
        m_pred = 1;
      end else begin
        m_pc = m_pc + 4;
        m_pred = 0;
      end
      if (upd_valid) begin
        u = int'((upd_pc / 4) % 8);
        if (upd_taken) begin
          bv[u] = 1; bline[u] = upd_pc / 32; btgt[u] = upd_target;
        end else if (bline[u] == upd_pc / 32) begin
          bv[u] = 0;
        end
      end
    end
    e.pc = m_pc; e.ce = m_ce; e.pred = m_pred; e.mis = mis;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic train(input logic [31:0] a, input logic [31:0] t,
                       input logic tk);
    upd_valid = 1; upd_pc = a; upd_target = t; upd_taken = tk;
  endtask

  task automatic jump(input logic [31:0] a);
    jump_flag = 1; jump_addr = a;
  endtask

  // Monitor: one expected entry per clock edge the driver issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({pc, ce, pred_taken, misalign} !== {e.pc, e.ce, e.pred, e.mis}) begin
          bad++;
          $display("FAIL cyc%0d pc/ce/pred/mis got %h/%b/%b/%b want %h/%b/%b/%b",
                   total, pc, ce, pred_taken, misalign,
                   e.pc, e.ce, e.pred, e.mis);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      bv[k] = 0; bline[k] = 0; btgt[k] = 0;
    end
    idle();
    rst = 1; cyc(); cyc();
    rst = 0; repeat (5) cyc();

    trap_valid = 1; trap_addr = 32'h100;
    jump(32'h200); hold_flag = 3'b001; cyc();
    idle(); cyc();

    jump(32'h203); cyc();
    idle(); cyc(); cyc();

    train(32'h10, 32'h80, 1); cyc();
    idle(); jump(32'h8); cyc();
    idle(); repeat (4) cyc();
    train(32'h10, 32'h0, 0); cyc();
    idle(); jump(32'h10); cyc();
    idle(); cyc(); cyc();

    train(32'h10, 32'h80, 1); cyc();
    idle(); jump(32'h30); cyc();
    idle(); cyc();
    hold_flag = 3'b001; repeat (3) cyc();
    hold_flag = 3'b110; fetch_ready = 0; repeat (3) cyc();
    idle(); cyc();

    jump(32'hFFFF_FFF8); cyc();
    idle(); repeat (3) cyc();

    train(32'h40, 32'h90, 1); cyc();
    idle(); jump(32'h3C); cyc();
    idle(); cyc(); cyc();
    jump(32'h40); rst = 1; cyc();
    idle(); cyc();
    jump(32'h40); cyc();
    idle(); cyc(); cyc();

    for (int n = 0; n < 400; n++) begin
      idle();
      rst         = ($urandom_range(0, 99) < 2);
      trap_valid  = ($urandom_range(0, 99) < 5);
      trap_addr   = $urandom_range(0, 255);
      jump_flag   = ($urandom_range(0, 99) < 10);
      jump_addr   = $urandom_range(0, 255);
      hold_flag   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 60) hold_flag[0] = 1'b0;
      fetch_ready = ($urandom_range(0, 99) < 80);
      upd_valid   = ($urandom_range(0, 99) < 30);
      upd_pc      = $urandom_range(0, 255);
      upd_target  = $urandom_range(0, 255);
      upd_taken   = ($urandom_range(0, 99) < 70);
      cyc();
    end
    idle();

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
